// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron datapath and its write-side loader:
// default geometry, loader state encoding and slot packing helper.
package perceptron_pkg;

    localparam int DEFAULT_N_INPUTS = 50;
    localparam int DEFAULT_DATA_W   = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FIRE  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } loader_state_e;

    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/perceptron_loader.sv
// Assembles serial (input, coefficient) beats into flat perceptron buses and pulses enable.
// Optional feature: define PERCEPTRON_LOADER_ZERO_PAD_EN to zero-fill and fire short frames.
module perceptron_loader
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = DEFAULT_N_INPUTS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic [DATA_W-1:0]          s_coeff,
    input  logic                       s_last,
    output logic [N_INPUTS*DATA_W-1:0] inputs_bus,
    output logic [N_INPUTS*DATA_W-1:0] coeffs_bus,
    output logic                       enable,
    output logic                       busy,
    output logic                       len_err,
    output logic [CNT_W-1:0]           frames_fired
);

    localparam int IDX_W = $clog2(N_INPUTS);

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drain_q, drain_d;
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             load_beat;
    logic             at_last;

    assign load_beat = (state_q == LOAD) && s_valid;
    assign at_last   = (idx_q == IDX_W'(N_INPUTS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        len_err_d = 1'b0;
        frames_d  = frames_q;
        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    if (at_last) begin
                        state_d   = FIRE;
                        idx_d     = '0;
                        drain_d   = !s_last;
                        len_err_d = !s_last;
                    end else if (s_last) begin
                        idx_d = '0;
`ifdef PERCEPTRON_LOADER_ZERO_PAD_EN
                        state_d = FIRE;
`else
                        len_err_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FIRE: begin
                state_d  = HOLD;
                frames_d = frames_q + 1'b1;
            end
            HOLD: begin
                state_d = drain_q ? DRAIN : LOAD;
                drain_d = 1'b0;
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            drain_q   <= 1'b0;
            len_err_q <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            len_err_q <= len_err_d;
            frames_q  <= frames_d;
        end
    end

    // One register pair per slot; only the slot addressed by idx captures a beat.
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_slot
        localparam int LSB = slot_lsb(i, DATA_W);
        logic [DATA_W-1:0] data_q, data_d;
        logic [DATA_W-1:0] coeff_q, coeff_d;

        always_comb begin
            data_d  = data_q;
            coeff_d = coeff_q;
            if (load_beat && idx_q == IDX_W'(i)) begin
                data_d  = s_data;
                coeff_d = s_coeff;
            end
`ifdef PERCEPTRON_LOADER_ZERO_PAD_EN
            else if (load_beat && s_last && idx_q < IDX_W'(i)) begin
                data_d  = '0;
                coeff_d = '0;
            end
`endif
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q  <= '0;
                coeff_q <= '0;
            end else begin
                data_q  <= data_d;
                coeff_q <= coeff_d;
            end
        end

        assign inputs_bus[LSB +: DATA_W] = data_q;
        assign coeffs_bus[LSB +: DATA_W] = coeff_q;
    end

    assign s_ready      = (state_q == LOAD) || (state_q == DRAIN);
    assign enable       = (state_q == FIRE);
    assign busy         = (state_q == FIRE) || (state_q == HOLD);
    assign len_err      = len_err_q;
    assign frames_fired = frames_q;

endmodule

// File: tb/tb_perceptron_loader.sv
// Randomized self-checking bench for perceptron_loader against a frame-level model.
// Honours PERCEPTRON_LOADER_ZERO_PAD_EN when the build defines it.
module tb_perceptron_loader;

    localparam int N  = 50;
    localparam int W  = 16;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic [W-1:0]   s_data = '0;
    logic [W-1:0]   s_coeff = '0;
    logic           s_ready, enable, busy, len_err;
    logic [N*W-1:0] inputs_bus, coeffs_bus;
    logic [CW-1:0]  frames_fired;

    logic           s_ready_s, enable_s, busy_s, len_err_s;
    logic [N*W-1:0] inputs_bus_s, coeffs_bus_s;
    logic [1:0]     frames_fired_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int en_cyc = -1;

    logic [W-1:0]   bd [0:63];
    logic [W-1:0]   bc [0:63];
    int             acc_cyc [0:63];
    logic [N*W-1:0] exp_in, exp_cf;
    int             exp_frames;

    perceptron_loader #(.N_INPUTS(N), .DATA_W(W), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_coeff(s_coeff), .s_last(s_last),
        .inputs_bus(inputs_bus), .coeffs_bus(coeffs_bus), .enable(enable),
        .busy(busy), .len_err(len_err), .frames_fired(frames_fired)
    );

    perceptron_loader #(.N_INPUTS(N), .DATA_W(W), .CNT_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready_s),
        .s_data(s_data), .s_coeff(s_coeff), .s_last(s_last),
        .inputs_bus(inputs_bus_s), .coeffs_bus(coeffs_bus_s), .enable(enable_s),
        .busy(busy_s), .len_err(len_err_s), .frames_fired(frames_fired_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (enable) begin
                en_cnt = en_cnt + 1;
                en_cyc = cyc;
            end
            if (len_err) err_cnt = err_cnt + 1;
        end
    end

    task automatic clear_model();
        exp_in     = '0;
        exp_cf     = '0;
        exp_frames = 0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            bd[b] = W'($urandom);
            bc[b] = W'($urandom);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives beats; returns #1 after the edge that accepted the last beat.
    task automatic send_frame(input int nbeats, input int last_pos, input bit gaps);
        int wait_cnt;
        int idle;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                idle = $urandom_range(0, 3);
                for (int k = 0; k < idle; k++) begin
                    s_valid = 1'b0;
                    s_data  = W'($urandom);
                    s_coeff = W'($urandom);
                    s_last  = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b1;
            s_data  = bd[b];
            s_coeff = bc[b];
            s_last  = (b == last_pos);
            wait_cnt = 0;
            while (!s_ready && wait_cnt < 100) begin
                @(posedge clk);
                #1;
                wait_cnt++;
            end
            checks++;
            if (!s_ready) begin
                errors++;
                $display("[TB] FAIL handshake_timeout: beat %0d s_ready=%b required 1", b, s_ready);
                break;
            end
            @(posedge clk);
            #1;
            acc_cyc[b] = cyc;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic model_write(input int nslots);
        for (int b = 0; b < nslots; b++) begin
            exp_in[b*W +: W] = bd[b];
            exp_cf[b*W +: W] = bc[b];
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        reset_n = 1'b0;
        clear_model();
        #2;
        checks++;
        if ({enable, busy, len_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: enable/busy/len_err=%b required 000", {enable, busy, len_err});
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b required 1", s_ready);
        end
        checks++;
        if (inputs_bus !== '0 || coeffs_bus !== '0 || frames_fired !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: buses/frames not zero, frames=%0d", frames_fired);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int en0, err0;
        en0  = en_cnt;
        err0 = err_cnt;
        for (int b = 0; b < N; b++) begin
            bd[b] = W'(b + 1);
            bc[b] = W'(2);
        end
        send_frame(N, N - 1, 1'b0);
        model_write(N);
        exp_frames++;
        wait_cycles(2);
        checks++;
        if (en_cnt - en0 != 1 || en_cyc != acc_cyc[N-1]) begin
            errors++;
            $display("[TB] FAIL full_enable: pulses=%0d at cycle %0d, required 1 at cycle %0d", en_cnt - en0, en_cyc, acc_cyc[N-1]);
        end
        checks++;
        if (err_cnt != err0) begin
            errors++;
            $display("[TB] FAIL full_len_err: pulses=%0d required 0", err_cnt - err0);
        end
        checks++;
        if (inputs_bus[W-1:0] !== 16'd1 || coeffs_bus[W-1:0] !== 16'd2) begin
            errors++;
            $display("[TB] FAIL full_slot0: got %0d/%0d required 1/2", inputs_bus[W-1:0], coeffs_bus[W-1:0]);
        end
        checks++;
        if (inputs_bus[(N-1)*W +: W] !== 16'd50 || coeffs_bus[(N-1)*W +: W] !== 16'd2) begin
            errors++;
            $display("[TB] FAIL full_slot49: got %0d/%0d required 50/2", inputs_bus[(N-1)*W +: W], coeffs_bus[(N-1)*W +: W]);
        end
        checks++;
        if (frames_fired !== CW'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL full_frames: got %0d required %0d", frames_fired, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        fill_random(N);
        send_frame(N, N - 1, 1'b1);
        model_write(N);
        exp_frames++;
        checks++;
        if ({enable, busy, s_ready} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL bp_fire_cycle: enable/busy/s_ready=%b required 110", {enable, busy, s_ready});
        end
        wait_cycles(1);
        checks++;
        if ({enable, busy, s_ready} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL bp_hold_cycle: enable/busy/s_ready=%b required 010", {enable, busy, s_ready});
        end
        wait_cycles(1);
        checks++;
        if ({enable, busy, s_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL bp_reload_cycle: enable/busy/s_ready=%b required 001", {enable, busy, s_ready});
        end
        checks++;
        if (inputs_bus !== exp_in || coeffs_bus !== exp_cf) begin
            errors++;
            $display("[TB] FAIL bp_buses: inputs %h required %h", inputs_bus, exp_in);
        end
        checks++;
        if (frames_fired !== CW'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL bp_frames: got %0d required %0d", frames_fired, exp_frames);
        end
    endtask

    task automatic test_short_frame();
        int en0, err0;
        en0  = en_cnt;
        err0 = err_cnt;
        fill_random(11);
        send_frame(11, 10, 1'b0);
        model_write(11);
`ifdef PERCEPTRON_LOADER_ZERO_PAD_EN
        exp_in[N*W-1:11*W] = '0;
        exp_cf[N*W-1:11*W] = '0;
        exp_frames++;
`endif
        wait_cycles(3);
        checks++;
`ifdef PERCEPTRON_LOADER_ZERO_PAD_EN
        if (en_cnt - en0 != 1 || err_cnt != err0) begin
            errors++;
            $display("[TB] FAIL short_pulses: enable=%0d len_err=%0d required 1/0", en_cnt - en0, err_cnt - err0);
        end
`else
        if (en_cnt != en0 || err_cnt - err0 != 1) begin
            errors++;
            $display("[TB] FAIL short_pulses: enable=%0d len_err=%0d required 0/1", en_cnt - en0, err_cnt - err0);
        end
`endif
        checks++;
        if (inputs_bus !== exp_in || coeffs_bus !== exp_cf) begin
            errors++;
            $display("[TB] FAIL short_buses: inputs %h required %h", inputs_bus, exp_in);
        end
        checks++;
        if (frames_fired !== CW'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL short_frames: got %0d required %0d", frames_fired, exp_frames);
        end
    endtask

    task automatic test_long_frame();
        int en0, err0;
        en0  = en_cnt;
        err0 = err_cnt;
        fill_random(N + 3);
        send_frame(N + 3, N + 2, 1'b0);
        model_write(N);
        exp_frames++;
        wait_cycles(3);
        checks++;
        if (en_cnt - en0 != 1 || en_cyc != acc_cyc[N-1]) begin
            errors++;
            $display("[TB] FAIL long_enable: pulses=%0d at cycle %0d, required 1 at cycle %0d", en_cnt - en0, en_cyc, acc_cyc[N-1]);
        end
        checks++;
        if (err_cnt - err0 != 1) begin
            errors++;
            $display("[TB] FAIL long_len_err: pulses=%0d required 1", err_cnt - err0);
        end
        checks++;
        if (inputs_bus !== exp_in || coeffs_bus !== exp_cf) begin
            errors++;
            $display("[TB] FAIL long_buses: inputs %h required %h", inputs_bus, exp_in);
        end
        fill_random(N);
        send_frame(N, N - 1, 1'b1);
        model_write(N);
        exp_frames++;
        wait_cycles(2);
        checks++;
        if (inputs_bus !== exp_in || coeffs_bus !== exp_cf || en_cnt - en0 != 2) begin
            errors++;
            $display("[TB] FAIL long_next_frame: enable pulses=%0d required 2, inputs %h required %h", en_cnt - en0, inputs_bus, exp_in);
        end
        checks++;
        if (frames_fired !== CW'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL long_frames: got %0d required %0d", frames_fired, exp_frames);
        end
    endtask

    task automatic test_async_reset();
        int en0;
        en0 = en_cnt;
        fill_random(25);
        send_frame(25, -1, 1'b0);
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if ({enable, busy, len_err} !== 3'b000 || inputs_bus !== '0 || coeffs_bus !== '0 || frames_fired !== '0) begin
            errors++;
            $display("[TB] FAIL reset_midframe: enable/busy/len_err=%b frames=%0d required all zero", {enable, busy, len_err}, frames_fired);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        fill_random(N);
        send_frame(N, N - 1, 1'b0);
        model_write(N);
        exp_frames++;
        wait_cycles(2);
        checks++;
        if (inputs_bus !== exp_in || coeffs_bus !== exp_cf || frames_fired !== CW'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL reset_restart: frames=%0d required %0d, inputs %h required %h", frames_fired, exp_frames, inputs_bus, exp_in);
        end
        fill_random(N);
        send_frame(N, N - 1, 1'b0);
        checks++;
        if (enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_fire_entry: enable=%b required 1", enable);
        end
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if ({enable, busy} !== 2'b00 || inputs_bus !== '0 || frames_fired !== '0) begin
            errors++;
            $display("[TB] FAIL reset_in_fire: enable/busy=%b frames=%0d required zero", {enable, busy}, frames_fired);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(4);
        checks++;
        if (en_cnt - en0 != 1 || frames_fired !== '0) begin
            errors++;
            $display("[TB] FAIL reset_no_glitch: enable pulses=%0d required 1, frames=%0d required 0", en_cnt - en0, frames_fired);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int f = 0; f < 5; f++) begin
            fill_random(N);
            send_frame(N, N - 1, f[0]);
            exp_frames++;
            wait_cycles(2);
        end
        checks++;
        if (frames_fired !== CW'(exp_frames)) begin
            errors++;
            $display("[TB] FAIL wrap_wide: got %0d required %0d", frames_fired, exp_frames);
        end
        checks++;
        if (frames_fired_s !== 2'(exp_frames % 4)) begin
            errors++;
            $display("[TB] FAIL wrap_narrow: got %0d required %0d", frames_fired_s, exp_frames % 4);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_async_reset();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
